conv_result_streamer: RTL and testbench

Output-side companion to `conv3x3`. It captures the packed `filtered_matrix` when `conv3x3` raises `done`, then serializes the valid (rows-2)x(cols-2) window in row-major order over a valid/ready pixel stream. Each beat carries the raw Q-format value, an 8-bit clamped pixel, coordinates and framing flags. It sits between the convolution core and the downstream display/UART/memory writer.

---
 rtl/conv_result_streamer.sv | 138 +++++++++++++
 tb/tb_conv_result_streamer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_streamer.sv
// Captures a conv3x3 result frame on the rising edge of done and streams the (rows-2)x(cols-2) window row-major.
// First beat one cycle after capture, one beat per cycle while out_ready is high; all out_* hold while stalled.
module conv_result_streamer #(
  parameter int total_bits = 16,
  parameter int frac_bits  = 8,
  parameter int max_rows   = 8,
  parameter int max_cols   = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [3:0]                                    rows,
  input  logic [3:0]                                    cols,
  input  logic [(max_rows-2)*(max_cols-2)*total_bits-1:0] filtered_matrix,
  input  logic                                          done,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [total_bits-1:0]                         out_data,
  output logic [7:0]                                    out_pix,
  output logic [3:0]                                    out_row,
  output logic [3:0]                                    out_col,
  output logic                                          out_sol,
  output logic                                          out_eol,
  output logic                                          out_eof,
  output logic                                          busy,
  output logic                                          frame_done,
  output logic                                          err,
  output logic                                          overrun
);

  localparam int n_elem   = (max_rows-2)*(max_cols-2);
  localparam int mat_bits = n_elem*total_bits;
  localparam int base_w   = $clog2(mat_bits);
  localparam logic [3:0] rows_hi = 4'(max_rows);
  localparam logic [3:0] cols_hi = 4'(max_cols);
  localparam logic signed [total_bits-1:0] one_q = total_bits'(1) << frac_bits;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state, state_nxt;
  logic                   done_q;
  logic [3:0]             r, c;
  logic [3:0]             rows_q, cols_q;
  logic [mat_bits-1:0]    mat_q;

  logic                   start, size_ok, capture, active, fire;
  logic                   at_eol, at_eof;
  logic [7:0]             idx;
  logic [base_w-1:0]      base;
  logic signed [total_bits-1:0] v;

  assign start   = done & ~done_q;
  assign size_ok = (rows >= 4'd3) && (rows <= rows_hi) && (cols >= 4'd3) && (cols <= cols_hi);
  assign active  = (state == STREAM);
  assign fire    = active & out_ready;
  assign at_eol  = (c == cols_q - 4'd3);
  assign at_eof  = at_eol && (r == rows_q - 4'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start && size_ok) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (fire && at_eof) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      r          <= '0;
      c          <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      mat_q      <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_q     <= done;
      frame_done <= fire & at_eof;
      err        <= start & ~size_ok & (state == IDLE);
      overrun    <= start & active;
      if (capture) begin
        mat_q  <= filtered_matrix;
        rows_q <= rows;
        cols_q <= cols;
        r      <= '0;
        c      <= '0;
      end else if (fire) begin
        if (at_eof) begin
          r <= '0;
          c <= '0;
        end else if (at_eol) begin
          r <= r + 4'd1;
          c <= '0;
        end else begin
          c <= c + 4'd1;
        end
      end
    end
  end

  // Element (r,c) sits at stride (cols-2) of the latched frame.
  always_comb begin
    idx  = {4'd0, r} * {4'd0, cols_q - 4'd2} + {4'd0, c};
    base = base_w'(idx) * base_w'(total_bits);
    v    = active ? $signed(mat_q[base +: total_bits]) : '0;
  end

  always_comb begin
    out_pix = v[frac_bits-1 -: 8];
    if (v < 0)          out_pix = 8'd0;
    else if (v >= one_q) out_pix = 8'd255;
  end

  assign out_valid = active;
  assign busy      = active;
  assign out_data  = v;
  assign out_row   = active ? r : 4'd0;
  assign out_col   = active ? c : 4'd0;
  assign out_sol   = active & (c == 4'd0);
  assign out_eol   = active & at_eol;
  assign out_eof   = active & at_eof;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: queue-based frame model plus literal pins per scenario.
module tb_conv_result_streamer;

  localparam int mat_bits = 36*16;

  logic                clk;
  logic                rst_n;
  logic [3:0]          rows, cols;
  logic [mat_bits-1:0] fm;
  logic                done;
  logic                out_valid, out_ready;
  logic [15:0]         out_data;
  logic [7:0]          out_pix;
  logic [3:0]          out_row, out_col;
  logic                out_sol, out_eol, out_eof;
  logic                busy, frame_done, err, overrun;

  conv_result_streamer #(.total_bits(16), .frac_bits(8), .max_rows(8), .max_cols(8)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols), .filtered_matrix(fm), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pix(out_pix),
    .out_row(out_row), .out_col(out_col), .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done), .err(err), .overrun(overrun)
  );

  typedef struct {
    int data; int pix; int row; int col;
    bit sol; bit eol; bit eof; int cyc;
  } beat_t;

  beat_t q[$];
  beat_t log_q[$];
  beat_t e_m;
  int    vals[36];
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0, beats = 0, err_cnt = 0, ovr_cnt = 0, fd_cnt = 0;
  bit    fd_pend = 0;
  bit    ready_mode = 0;
  bit [3:0] pat = 4'b1001;
  int    ph = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int pix_of(input int v);
    if (v < 0) return 0;
    if (v >= 256) return 255;
    return v;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode) begin
        out_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Compare process: every live cycle the stream must match the front of the model queue.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      fd_pend = 0;
    end else begin
      check("frame_done", frame_done, fd_pend);
      fd_pend = 0;
      check("out_valid", out_valid, q.size() != 0);
      check("busy", busy, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        e_m = q[0];
        check("out_data", $signed(out_data), e_m.data);
        check("out_pix", out_pix, e_m.pix);
        check("out_row", out_row, e_m.row);
        check("out_col", out_col, e_m.col);
        check("out_sol", out_sol, e_m.sol);
        check("out_eol", out_eol, e_m.eol);
        check("out_eof", out_eof, e_m.eof);
        if (out_ready) begin
          e_m.data = $signed(out_data); e_m.pix = out_pix;
          e_m.row = out_row; e_m.col = out_col;
          e_m.sol = out_sol; e_m.eol = out_eol; e_m.eof = out_eof;
          e_m.cyc = cyc;
          log_q.push_back(e_m);
          void'(q.pop_front());
          beats++;
          if (e_m.eof) fd_pend = 1;
        end
      end
      if (err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic run_frame(input int nr, input int nc, input bit legal, input bit hold);
    beat_t e;
    @(posedge clk); #1;
    rows = 4'(nr);
    cols = 4'(nc);
    fm = '0;
    if (legal)
      for (int k = 0; k < (nr-2)*(nc-2); k++) fm[k*16 +: 16] = 16'(vals[k]);
    done = 1'b1;
    @(posedge clk); #1;
    if (legal) begin
      for (int rr = 0; rr <= nr-3; rr++)
        for (int cc = 0; cc <= nc-3; cc++) begin
          e.data = vals[rr*(nc-2)+cc];
          e.pix  = pix_of(e.data);
          e.row  = rr; e.col = cc;
          e.sol  = (cc == 0);
          e.eol  = (cc == nc-3);
          e.eof  = (cc == nc-3) && (rr == nr-3);
          e.cyc  = 0;
          q.push_back(e);
        end
    end
    if (!hold) done = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || fd_pend) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_budget", (q.size() == 0 && !fd_pend), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_pix"}, out_pix, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_flags"}, {out_sol, out_eol, out_eof}, 0);
    check({tag, "_pulses"}, {frame_done, err, overrun}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, l0, e0, o0, f0, n;
    rst_n = 1'b0; done = 1'b0; rows = '0; cols = '0; fm = '0;
    #3;
    check_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 2x2 frame, ready held high
    for (int k = 0; k < 4; k++) vals[k] = k*16;
    l0 = log_q.size(); f0 = fd_cnt;
    run_frame(4, 4, 1, 0);
    wait_drain(50);
    check("t1_beats", log_q.size() - l0, 4);
    if (log_q.size() - l0 == 4) begin
      check("t1_d0", log_q[l0].data, 0);
      check("t1_d1", log_q[l0+1].data, 16);
      check("t1_d2", log_q[l0+2].data, 32);
      check("t1_d3", log_q[l0+3].data, 48);
      check("t1_rc2", log_q[l0+2].row*16 + log_q[l0+2].col, 16);
      check("t1_eol", {log_q[l0].eol, log_q[l0+1].eol, log_q[l0+2].eol, log_q[l0+3].eol}, 4'b0101);
      check("t1_eof", {log_q[l0].eof, log_q[l0+1].eof, log_q[l0+2].eof, log_q[l0+3].eof}, 4'b0001);
      check("t1_back_to_back", log_q[l0+3].cyc - log_q[l0].cyc, 3);
    end
    check("t1_frame_done_cnt", fd_cnt - f0, 1);

    // 8x8 with backpressure 1,0,0,1
    for (int k = 0; k < 36; k++) vals[k] = k;
    ready_mode = 1;
    l0 = log_q.size();
    run_frame(8, 8, 1, 0);
    wait_drain(1000);
    ready_mode = 0;
    check("t2_beats", log_q.size() - l0, 36);
    if (log_q.size() - l0 == 36)
      for (int i = 0; i < 36; i++) begin
        check("t2_order", log_q[l0+i].data, i);
        check("t2_sol", log_q[l0+i].sol, (i % 6) == 0);
      end

    // clamp
    vals[0] = -512; vals[1] = 0; vals[2] = 128; vals[3] = 255; vals[4] = 256; vals[5] = 2048;
    l0 = log_q.size();
    run_frame(4, 5, 1, 0);
    wait_drain(50);
    check("t3_beats", log_q.size() - l0, 6);
    if (log_q.size() - l0 == 6) begin
      check("t3_pix0", log_q[l0].pix, 0);
      check("t3_pix1", log_q[l0+1].pix, 0);
      check("t3_pix2", log_q[l0+2].pix, 128);
      check("t3_pix3", log_q[l0+3].pix, 255);
      check("t3_pix4", log_q[l0+4].pix, 255);
      check("t3_pix5", log_q[l0+5].pix, 255);
      check("t3_raw0", log_q[l0].data, -512);
      check("t3_raw5", log_q[l0+5].data, 2048);
    end

    // minimum 3x3 frame: single beat carries sol, eol and eof
    vals[0] = -1;
    l0 = log_q.size();
    run_frame(3, 3, 1, 0);
    wait_drain(50);
    check("t4_beats", log_q.size() - l0, 1);
    if (log_q.size() - l0 == 1) begin
      check("t4_flags", {log_q[l0].sol, log_q[l0].eol, log_q[l0].eof}, 3'b111);
      check("t4_pix", log_q[l0].pix, 0);
    end

    // illegal sizes
    e0 = err_cnt; b0 = beats;
    run_frame(2, 8, 0, 0);
    repeat (4) @(posedge clk);
    check("t5_err_rows2", err_cnt - e0, 1);
    run_frame(8, 9, 0, 0);
    repeat (4) @(posedge clk);
    check("t5_err_cols9", err_cnt - e0, 2);
    check("t5_no_beats", beats - b0, 0);

    // overrun with held done and altered input after capture
    for (int k = 0; k < 4; k++) vals[k] = 1000 + k;
    l0 = log_q.size(); o0 = ovr_cnt; f0 = fd_cnt;
    run_frame(4, 4, 1, 1);
    fm = {36{16'h7777}};
    @(posedge clk); #1; done = 1'b0;
    @(posedge clk); #1; done = 1'b1;
    repeat (8) @(posedge clk);
    wait_drain(50);
    check("t6_beats", log_q.size() - l0, 4);
    check("t6_overrun_cnt", ovr_cnt - o0, 1);
    check("t6_frame_done_cnt", fd_cnt - f0, 1);
    if (log_q.size() - l0 == 4) begin
      check("t6_d0", log_q[l0].data, 1000);
      check("t6_d3", log_q[l0+3].data, 1003);
    end
    done = 1'b0;
    repeat (2) @(posedge clk);

    // reset after beat 10 of an 8x8 frame
    for (int k = 0; k < 36; k++) vals[k] = 200 + k;
    b0 = beats;
    run_frame(8, 8, 1, 0);
    n = 0;
    while (beats < b0 + 10 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("t7_beat10_reached", beats - b0, 10);
    #1; rst_n = 1'b0;
    #1;
    check_outputs_zero("t7_async");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    b0 = beats;
    repeat (10) @(posedge clk);
    check("t7_no_beats_after_release", beats - b0, 0);
    for (int k = 0; k < 36; k++) vals[k] = k;
    l0 = log_q.size();
    run_frame(8, 8, 1, 0);
    wait_drain(200);
    check("t7_refill_beats", log_q.size() - l0, 36);
    if (log_q.size() - l0 == 36) begin
      check("t7_first_rc", log_q[l0].row*16 + log_q[l0].col, 0);
      check("t7_first_data", log_q[l0].data, 0);
      check("t7_last_data", log_q[l0+35].data, 35);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
